nx_node_router: RTL and testbench
=================================

NX_NODE_ROUTER -- requirements
Module: nx_node_router

Interface
REQ-001 SHALL have parameter MSG_W, default 31, message width in bits.
REQ-002 SHALL have parameter ROW_W, default 4, header row field width.
REQ-003 SHALL have parameter COL_W, default 4, header column field width.
REQ-004 SHALL have parameter FIFO_DEPTH, default 2, entries per outbound FIFO (power of two, >=2).
REQ-005 SHALL have port i_clk, input, 1, the block's single clock.
REQ-006 SHALL have port i_rst, input, 1, asynchronous active-high reset.
REQ-007 SHALL have port i_node_id, input, ROW_W+COL_W, {row, column} of this node.
REQ-008 SHALL have port i_idle, input, 1, downstream idle chain input.
REQ-009 SHALL have port o_idle, output, 1, chained idle.
REQ-010 SHALL have ports i_inbound_data/i_inbound_valid/o_inbound_ready, input/input/output, 4xMSG_W/4/4, neighbour inbound streams (0=N, 1=E, 2=S, 3=W).
REQ-011 SHALL have ports i_inject_data/i_inject_valid/o_inject_ready, input/input/output, MSG_W/1/1, local injection stream.
REQ-012 SHALL have ports o_outbound_data/o_outbound_valid/i_outbound_ready, output/output/input, 4xMSG_W/4/4, neighbour outbound streams.
REQ-013 SHALL have port i_outbound_present, input, 4, neighbour exists per direction.
REQ-014 SHALL have ports o_deliver_data/o_deliver_valid/i_deliver_ready, output/output/input, MSG_W/1/1, messages addressed to this node.

Function
REQ-015 Header fields SHALL be row = data[MSG_W-1 -: ROW_W] and column = data[MSG_W-ROW_W-1 -: COL_W].
REQ-016 A message whose row and column equal i_node_id SHALL route to deliver, including injected loopback messages.
- Otherwise direction SHALL be selected as follows:
  - row<own: N if present, else E.
  - row>own: S if present, else W.
  - row equal, col<own: W if present, else N.
  - row equal, col>own: E if present, else S.
REQ-017 Sources SHALL be indices 0-3 (inbound) and 4 (inject); at most one message SHALL be accepted per cycle.
REQ-018 A source SHALL be eligible when it is valid and its destination can accept a message this cycle.
- A FIFO can accept when it is not full, or when it is full and popping this cycle.
- The deliver register can accept when it is empty, or when it is full and i_deliver_ready=1.
REQ-019 The grant SHALL go to the first eligible source at or after the round-robin pointer.
- The pointer SHALL then move to grant+1, wrapping from 4 to 0.
- The pointer SHALL be held when nothing is granted.
REQ-020 Ready SHALL be asserted only to the granted source, and only in its grant cycle; a blocked source SHALL NOT stall other eligible sources.
REQ-021 Latency SHALL be one cycle: a message accepted in cycle N is valid at its output in cycle N+1.
REQ-022 Each outbound FIFO SHALL be first-in first-out, drive o_outbound_valid = not empty and o_outbound_data = head, and pop on valid&&ready.
REQ-023 A deliver message SHALL be held stable until i_deliver_ready=1.
REQ-024 Local idle SHALL be: all FIFOs empty, deliver register empty, and no inbound or inject valid; it SHALL be registered into idle_q.
REQ-025 o_idle SHALL equal idle_q && i_idle.
REQ-026 Data on non-valid outputs SHALL be don't-care.

Reset
REQ-027 On i_rst (asynchronous) the block SHALL:
- empty all FIFOs and the deliver register;
- set the round-robin pointer to 0;
- drive o_outbound_valid=0, o_deliver_valid=0, o_inbound_ready=0, o_inject_ready=0, idle_q=0.
REQ-028 Reset asserted mid-transfer SHALL discard all buffered messages with no partial output.

Configuration
REQ-029 When NX_ROUTER_STATS_EN is defined, the block SHALL add:
- input i_stat_clear, 1 bit;
- output o_stat_count, 5x16 bits, counting accepted messages per destination (N,E,S,W,deliver).
REQ-030 The counters SHALL saturate at 16'hFFFF, reset to 0, and clear synchronously on i_stat_clear; clear SHALL win over a same-cycle increment.
REQ-031 When NX_ROUTER_STATS_EN is undefined, these ports and counters SHALL be absent and routing behaviour SHALL be identical.

Verification
REQ-032 node_id=(2,3), all present; inbound N carries dest (0,3) -> accepted in 1 cycle, o_outbound_valid[0]=1 next cycle with the same data.
REQ-033 node_id=(2,3), present=4'b1011 (S absent); inject dest (5,3) -> routes to W; dest (2,3) -> o_deliver_valid=1 after 1 cycle.
REQ-034 All 5 sources valid continuously, targeting 5 distinct destinations, all outputs ready -> grants in the order 0,1,2,3,4,0, one per cycle.
REQ-035 FIFO_DEPTH=2, i_outbound_ready[1]=0; 3 messages to E plus 1 to deliver -> first two enter the FIFO, third held with its ready low, deliver message still accepted; releasing ready drains E in order.
REQ-036 STATS_EN, 70000 messages to S -> o_stat_count[2]=16'hFFFF; i_stat_clear pulsed together with a push -> count 0.
REQ-037 Reset asserted with 2 messages buffered -> all valids 0 immediately; after release o_idle=1 within 1 cycle given i_idle=1 and no inputs.

Source files
------------

// File: rtl/nx_node_router.sv
// nx_node_router: 5-source round-robin mesh node router with four outbound FIFOs and a local deliver register.
// Define NX_ROUTER_STATS_EN to add per-destination saturating message counters.
module nx_node_router #(
    parameter int MSG_W      = 31,
    parameter int ROW_W      = 4,
    parameter int COL_W      = 4,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic [ROW_W+COL_W-1:0]       i_node_id,
    input  logic                         i_idle,
    output logic                         o_idle,
    input  logic [3:0][MSG_W-1:0]        i_inbound_data,
    input  logic [3:0]                   i_inbound_valid,
    output logic [3:0]                   o_inbound_ready,
    input  logic [MSG_W-1:0]             i_inject_data,
    input  logic                         i_inject_valid,
    output logic                         o_inject_ready,
    output logic [3:0][MSG_W-1:0]        o_outbound_data,
    output logic [3:0]                   o_outbound_valid,
    input  logic [3:0]                   i_outbound_ready,
    input  logic [3:0]                   i_outbound_present,
    output logic [MSG_W-1:0]             o_deliver_data,
    output logic                         o_deliver_valid,
    input  logic                         i_deliver_ready
`ifdef NX_ROUTER_STATS_EN
    ,
    input  logic                         i_stat_clear,
    output logic [4:0][15:0]             o_stat_count
`endif
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = AW + 1;

    // Destination codes: 0..3 = N/E/S/W outbound, 4 = local deliver.
    function automatic logic [2:0] route_dest(
        input logic [MSG_W-1:0]       d,
        input logic [ROW_W+COL_W-1:0] own,
        input logic [3:0]             pres
    );
        logic [ROW_W-1:0] row, own_row;
        logic [COL_W-1:0] col, own_col;
        row     = d[MSG_W-1 -: ROW_W];
        col     = d[MSG_W-ROW_W-1 -: COL_W];
        own_row = own[ROW_W+COL_W-1 -: ROW_W];
        own_col = own[COL_W-1:0];
        if (row < own_row)      route_dest = pres[0] ? 3'd0 : 3'd1;
        else if (row > own_row) route_dest = pres[2] ? 3'd2 : 3'd3;
        else if (col < own_col) route_dest = pres[3] ? 3'd3 : 3'd0;
        else if (col > own_col) route_dest = pres[1] ? 3'd1 : 3'd2;
        else                    route_dest = 3'd4;
    endfunction

    logic [4:0][MSG_W-1:0] src_data;
    logic [4:0]            src_valid;
    logic [4:0][2:0]       src_dest;
    logic [4:0]            dest_ok;
    logic [4:0]            eligible;
    logic [4:0]            push;
    logic [3:0]            pop;
    logic [3:0]            fifo_empty;

    logic                  grant_valid;
    logic [2:0]            grant_idx;
    logic [2:0]            grant_dest;
    logic [MSG_W-1:0]      grant_data;
    logic [4:0]            grant_onehot;
    logic [3:0]            cand;

    logic [2:0]            ptr_q, ptr_d;
    logic                  dlv_valid_q, dlv_valid_d;
    logic [MSG_W-1:0]      dlv_data_q, dlv_data_d;
    logic                  idle_q, idle_d;

    assign src_data  = {i_inject_data, i_inbound_data};
    assign src_valid = {i_inject_valid, i_inbound_valid};

    genvar gi;
    generate
        for (gi = 0; gi < 5; gi++) begin : g_src
            assign src_dest[gi] = route_dest(src_data[gi], i_node_id, i_outbound_present);
            assign eligible[gi] = !i_rst && src_valid[gi] && dest_ok[src_dest[gi]];
            assign push[gi]     = grant_valid && (grant_dest == 3'(gi));
        end
    endgenerate

    // Scan the five sources starting at the pointer; first eligible wins.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int k = 0; k < 5; k++) begin
            cand = {1'b0, ptr_q} + 4'(k);
            if (cand >= 4'd5) cand = cand - 4'd5;
            if (!grant_valid && eligible[cand[2:0]]) begin
                grant_valid = 1'b1;
                grant_idx   = cand[2:0];
            end
        end
        grant_dest   = src_dest[grant_idx];
        grant_data   = src_data[grant_idx];
        grant_onehot = grant_valid ? (5'b00001 << grant_idx) : 5'b00000;
        ptr_d        = ptr_q;
        if (grant_valid) ptr_d = (grant_idx == 3'd4) ? 3'd0 : grant_idx + 3'd1;
    end

    assign o_inbound_ready = grant_onehot[3:0];
    assign o_inject_ready  = grant_onehot[4];

    generate
        for (gi = 0; gi < 4; gi++) begin : g_fifo
            logic [MSG_W-1:0] mem [FIFO_DEPTH];
            logic [AW-1:0]    wr_q, wr_d, rd_q, rd_d;
            logic [CW-1:0]    cnt_q, cnt_d;

            always_comb begin
                wr_d  = wr_q;
                rd_d  = rd_q;
                if (push[gi]) wr_d = wr_q + AW'(1);
                if (pop[gi])  rd_d = rd_q + AW'(1);
                cnt_d = cnt_q + CW'(push[gi]) - CW'(pop[gi]);
            end

            always_ff @(posedge i_clk or posedge i_rst) begin
                if (i_rst) begin
                    wr_q  <= '0;
                    rd_q  <= '0;
                    cnt_q <= '0;
                end else begin
                    wr_q  <= wr_d;
                    rd_q  <= rd_d;
                    cnt_q <= cnt_d;
                end
            end

            // Storage needs no reset: occupancy alone decides what is visible.
            always_ff @(posedge i_clk) begin
                if (push[gi]) mem[wr_q] <= grant_data;
            end

            assign o_outbound_valid[gi] = (cnt_q != '0);
            assign o_outbound_data[gi]  = mem[rd_q];
            assign pop[gi]              = o_outbound_valid[gi] && i_outbound_ready[gi];
            assign dest_ok[gi]          = (cnt_q != CW'(FIFO_DEPTH)) || pop[gi];
            assign fifo_empty[gi]       = (cnt_q == '0);
        end
    endgenerate

    assign dest_ok[4] = !dlv_valid_q || i_deliver_ready;

    always_comb begin
        dlv_valid_d = dlv_valid_q;
        dlv_data_d  = dlv_data_q;
        if (push[4]) begin
            dlv_valid_d = 1'b1;
            dlv_data_d  = grant_data;
        end else if (i_deliver_ready) begin
            dlv_valid_d = 1'b0;
        end
        idle_d = (&fifo_empty) && !dlv_valid_q && !(|i_inbound_valid) && !i_inject_valid;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            ptr_q       <= '0;
            dlv_valid_q <= 1'b0;
            dlv_data_q  <= '0;
            idle_q      <= 1'b0;
        end else begin
            ptr_q       <= ptr_d;
            dlv_valid_q <= dlv_valid_d;
            dlv_data_q  <= dlv_data_d;
            idle_q      <= idle_d;
        end
    end

    assign o_deliver_valid = dlv_valid_q;
    assign o_deliver_data  = dlv_data_q;
    assign o_idle          = idle_q && i_idle;

`ifdef NX_ROUTER_STATS_EN
    generate
        for (gi = 0; gi < 5; gi++) begin : g_stat
            logic [15:0] cnt_q, cnt_d;

            // Clear takes priority over a same-cycle increment.
            always_comb begin
                cnt_d = cnt_q;
                if (i_stat_clear)                     cnt_d = '0;
                else if (push[gi] && cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
            end

            always_ff @(posedge i_clk or posedge i_rst) begin
                if (i_rst) cnt_q <= '0;
                else       cnt_q <= cnt_d;
            end

            assign o_stat_count[gi] = cnt_q;
        end
    endgenerate
`endif

endmodule

// File: tb/tb_nx_node_router.sv
// Randomised and directed bench for nx_node_router against a queue-based reference model.
module tb_nx_node_router;

    localparam int MSG_W = 31;
    localparam int ROW_W = 4;
    localparam int COL_W = 4;
    localparam int DEPTH = 2;
    localparam int PW    = MSG_W - ROW_W - COL_W;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [ROW_W+COL_W-1:0] node_id;
    logic                  idle_in;
    logic                  idle_out;
    logic [3:0][MSG_W-1:0] in_data;
    logic [3:0]            in_valid;
    logic [3:0]            in_ready;
    logic [MSG_W-1:0]      inj_data;
    logic                  inj_valid;
    logic                  inj_ready;
    logic [3:0][MSG_W-1:0] ob_data;
    logic [3:0]            ob_valid;
    logic [3:0]            ob_rdy;
    logic [3:0]            pres;
    logic [MSG_W-1:0]      dl_data;
    logic                  dl_valid;
    logic                  dl_rdy;
`ifdef NX_ROUTER_STATS_EN
    logic                  stat_clr;
    logic [4:0][15:0]      stat_cnt;
`endif

    nx_node_router #(.MSG_W(MSG_W), .ROW_W(ROW_W), .COL_W(COL_W), .FIFO_DEPTH(DEPTH)) dut (
        .i_clk(clk), .i_rst(rst), .i_node_id(node_id), .i_idle(idle_in), .o_idle(idle_out),
        .i_inbound_data(in_data), .i_inbound_valid(in_valid), .o_inbound_ready(in_ready),
        .i_inject_data(inj_data), .i_inject_valid(inj_valid), .o_inject_ready(inj_ready),
        .o_outbound_data(ob_data), .o_outbound_valid(ob_valid), .i_outbound_ready(ob_rdy),
        .i_outbound_present(pres),
        .o_deliver_data(dl_data), .o_deliver_valid(dl_valid), .i_deliver_ready(dl_rdy)
`ifdef NX_ROUTER_STATS_EN
        , .i_stat_clear(stat_clr), .o_stat_count(stat_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_mis = 0;

    // Reference model state: pending source messages, outbound queues, deliver slot, pointer.
    logic [MSG_W-1:0] pend [5][$];
    logic [MSG_W-1:0] mq   [4][$];
    logic [MSG_W-1:0] dq   [$];
    int               rr_ptr;
    bit               exp_idle;
    int               mdl_g;
    int               dut_g;
    int               acc [5];
    logic [3:0]       own_r, own_c;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [MSG_W-1:0] mk(input logic [3:0] r, input logic [3:0] c);
        mk = {r, c, PW'($urandom)};
    endfunction

    function automatic int route(input logic [MSG_W-1:0] m);
        logic [3:0] r, c;
        r = m[MSG_W-1 -: 4];
        c = m[MSG_W-5 -: 4];
        if (r == own_r && c == own_c) return 4;
        if (r != own_r) return (r < own_r) ? (pres[0] ? 0 : 1) : (pres[2] ? 2 : 3);
        return (c < own_c) ? (pres[3] ? 3 : 0) : (pres[1] ? 1 : 2);
    endfunction

    function automatic bit can_take(input int d);
        if (d < 4) return (mq[d].size() < DEPTH) || ob_rdy[d];
        return (dq.size() == 0) || dl_rdy;
    endfunction

    task automatic drive();
        node_id = {own_r, own_c};
        for (int s = 0; s < 4; s++) begin
            in_valid[s] = pend[s].size() > 0;
            in_data[s]  = in_valid[s] ? pend[s][0] : '0;
        end
        inj_valid = pend[4].size() > 0;
        inj_data  = inj_valid ? pend[4][0] : '0;
    endtask

    // One clock: drive, compare all outputs against the model, then advance the model.
    task automatic step();
        logic [4:0] exp_rdy, got_rdy;
        bit         nxt_idle;
        drive();
        #1;
        mdl_g = -1;
        for (int k = 0; k < 5; k++) begin
            int s;
            s = (rr_ptr + k) % 5;
            if (mdl_g < 0 && pend[s].size() > 0 && can_take(route(pend[s][0]))) mdl_g = s;
        end
        exp_rdy = (mdl_g >= 0) ? 5'(1 << mdl_g) : 5'd0;
        got_rdy = {inj_ready, in_ready};
        dut_g = -1;
        for (int s = 0; s < 5; s++) if (got_rdy[s]) dut_g = s;
        check("ready", 64'(got_rdy), 64'(exp_rdy));
        for (int d = 0; d < 4; d++) begin
            check("ob_valid", 64'(ob_valid[d]), 64'(mq[d].size() > 0));
            if (mq[d].size() > 0) check("ob_data", 64'(ob_data[d]), 64'(mq[d][0]));
        end
        check("dl_valid", 64'(dl_valid), 64'(dq.size() > 0));
        if (dq.size() > 0) check("dl_data", 64'(dl_data), 64'(dq[0]));
        check("idle", 64'(idle_out), 64'(exp_idle && idle_in));

        nxt_idle = (dq.size() == 0);
        for (int s = 0; s < 5; s++) if (pend[s].size() > 0) nxt_idle = 0;
        for (int d = 0; d < 4; d++) begin
            if (mq[d].size() > 0) nxt_idle = 0;
            if (mq[d].size() > 0 && ob_rdy[d]) void'(mq[d].pop_front());
        end
        if (dq.size() > 0 && dl_rdy) void'(dq.pop_front());
        if (mdl_g >= 0) begin
            int d;
            d = route(pend[mdl_g][0]);
            if (d < 4) mq[d].push_back(pend[mdl_g][0]);
            else       dq.push_back(pend[mdl_g][0]);
            void'(pend[mdl_g].pop_front());
            acc[mdl_g]++;
            rr_ptr = (mdl_g + 1) % 5;
        end
        exp_idle = nxt_idle;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        check("rst_ob_valid", 64'(ob_valid), 64'd0);
        check("rst_dl_valid", 64'(dl_valid), 64'd0);
        check("rst_ready", 64'({inj_ready, in_ready}), 64'd0);
        for (int s = 0; s < 5; s++) begin pend[s].delete(); acc[s] = 0; end
        for (int d = 0; d < 4; d++) mq[d].delete();
        dq.delete();
        rr_ptr   = 0;
        exp_idle = 0;
        drive();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic random_phase(input int cycles);
        own_r = 4'($urandom_range(1, 14));
        own_c = 4'($urandom_range(1, 14));
        pres  = 4'($urandom);
        for (int n = 0; n < cycles; n++) begin
            for (int d = 0; d < 4; d++) ob_rdy[d] = ($urandom % 4) != 0;
            dl_rdy  = ($urandom % 3) != 0;
            idle_in = ($urandom % 4) != 0;
            for (int s = 0; s < 5; s++) begin
                if (pend[s].size() < 2 && ($urandom % 3) == 0) begin
                    logic [3:0] r, c;
                    r = (($urandom % 3) == 0) ? own_r : 4'($urandom);
                    c = (($urandom % 2) == 0) ? own_c : 4'($urandom);
                    pend[s].push_back(mk(r, c));
                end
            end
            step();
        end
        // Let everything drain so the next phase starts empty.
        ob_rdy = 4'hF;
        dl_rdy = 1'b1;
        for (int n = 0; n < 20; n++) step();
    endtask

    initial begin
        int exp_g [6];
        exp_g = '{0, 1, 2, 3, 4, 0};
        rst = 1'b1; own_r = 4'd2; own_c = 4'd3; pres = 4'hF;
        ob_rdy = 4'hF; dl_rdy = 1'b1; idle_in = 1'b1;
        in_data = '0; in_valid = '0; inj_data = '0; inj_valid = 1'b0;
`ifdef NX_ROUTER_STATS_EN
        stat_clr = 1'b0;
`endif
        pend[0].push_back(mk(4'd0, 4'd3));
        drive();
        @(negedge clk);
        do_reset();

        // Inbound N to (0,3) leaves on N one cycle later.
        pend[0].push_back(mk(4'd0, 4'd3));
        step();
        check("r32_grant", 64'(dut_g), 64'd0);
        check("r32_ob_valid", 64'(ob_valid[0]), 64'd1);
        step();

        // South absent: (5,3) falls back to W; own address goes to deliver.
        pres = 4'b1011;
        pend[4].push_back(mk(4'd5, 4'd3));
        step();
        check("r33_w_valid", 64'(ob_valid[3]), 64'd1);
        pend[4].push_back(mk(4'd2, 4'd3));
        step();
        check("r33_dl_valid", 64'(dl_valid), 64'd1);
        step(); step();

        // Five sources to five distinct destinations: strict rotation.
        pres = 4'hF;
        do_reset();
        for (int r = 0; r < 2; r++) begin
            pend[0].push_back(mk(4'd0, 4'd3));
            pend[1].push_back(mk(4'd2, 4'd7));
            pend[2].push_back(mk(4'd5, 4'd3));
            pend[3].push_back(mk(4'd2, 4'd0));
            pend[4].push_back(mk(4'd2, 4'd3));
        end
        for (int k = 0; k < 6; k++) begin
            step();
            check("r34_order", 64'(dut_g), 64'(exp_g[k]));
        end
        for (int n = 0; n < 10; n++) step();

        // E blocked: two fill the FIFO, third waits, deliver still flows.
        do_reset();
        ob_rdy = 4'b1101;
        for (int k = 0; k < 3; k++) pend[4].push_back(mk(4'd2, 4'd9));
        pend[0].push_back(mk(4'd2, 4'd3));
        for (int n = 0; n < 6; n++) step();
        check("r35_inj_acc", 64'(acc[4]), 64'd2);
        check("r35_dl_acc", 64'(acc[0]), 64'd1);
        check("r35_inj_held", 64'(inj_ready), 64'd0);
        ob_rdy = 4'hF;
        for (int n = 0; n < 6; n++) step();
        check("r35_inj_done", 64'(acc[4]), 64'd3);

        random_phase(300);
        random_phase(300);
        random_phase(300);

        // Reset with two buffered messages, then idle comes back.
        own_r = 4'd2; own_c = 4'd3; pres = 4'hF;
        do_reset();
        ob_rdy = 4'h0; idle_in = 1'b1;
        pend[0].push_back(mk(4'd0, 4'd3));
        pend[1].push_back(mk(4'd0, 4'd3));
        for (int n = 0; n < 3; n++) step();
        check("r37_buffered", 64'(ob_valid[0]), 64'd1);
        do_reset();
        step();
        check("r37_idle", 64'(idle_out), 64'd1);
        step();

`ifdef NX_ROUTER_STATS_EN
        do_reset();
        ob_rdy = 4'hF;
        in_valid = 4'b0001;
        in_data[0] = mk(4'd5, 4'd3);
        repeat (70000) @(posedge clk);
        @(negedge clk);
        check("r36_sat", 64'(stat_cnt[2]), 64'hFFFF);
        stat_clr = 1'b1;
        @(posedge clk);
        @(negedge clk);
        stat_clr = 1'b0;
        in_valid = 4'b0000;
        check("r36_clear", 64'(stat_cnt[2]), 64'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
